// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares a single-port, byte-addressed data memory between two requesters
//   (port 0: core load/store unit, port 1: debug/test loader). Round-robin
//   arbitration, one word transaction per grant, registered response.
//   Misaligned or out-of-range accesses are flagged as errors and never reach
//   the memory; they still receive a normal response.
//
// Ports
//   clk_i, reset_n           clock (rising edge), asynchronous active-low reset
//   mX_req_i                 request, held until mX_gnt_o
//   mX_we_i                  1 = write, 0 = read
//   mX_addr_i, mX_wdata_i    byte address and write data
//   mX_gnt_o                 grant pulse (combinational while idle)
//   mX_rvalid_o              response pulse, two cycles after the grant
//   mX_rdata_o, mX_err_o     read data / access error, qualified by mX_rvalid_o
//   mem_addr_o, mem_data_o   memory address / write data (driven in ACCESS only)
//   mem_write_o, mem_read_o  memory strobes (never asserted on error accesses)
//   mem_data_i               memory read data (combinational read)
//   busy_o                   transaction in flight
module dmem_port_arbiter #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [31:0]       mem_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    logic                last_owner;
    logic                owner;
    logic                err_q;
    logic                rv0_q;
    logic                rv1_q;
    logic [31:0]         rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_data_q;
    logic                mem_write_q;
    logic                mem_read_q;

    logic                any_req;
    logic                pick1;
    logic                grant_ok;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_err;

    // Winner selection: on contention the port not served last wins.
    always_comb begin
        any_req = m0_req_i | m1_req_i;
        pick1   = 1'b0;
        if (m0_req_i && m1_req_i) begin
            pick1 = ~last_owner;
        end else begin
            pick1 = m1_req_i;
        end
        sel_we    = pick1 ? m1_we_i    : m0_we_i;
        sel_addr  = pick1 ? m1_addr_i  : m0_addr_i;
        sel_wdata = pick1 ? m1_wdata_i : m0_wdata_i;
        sel_err   = (sel_addr[1:0] != 2'b00) | (sel_addr > ADDR_W'(DEPTH - 4));
    end

    // Grants are combinational; gating with reset_n keeps them low while
    // reset is held even though the FSM already sits in IDLE.
    assign grant_ok = reset_n & (state == IDLE) & any_req;
    assign m0_gnt_o = grant_ok & ~pick1;
    assign m1_gnt_o = grant_ok &  pick1;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            owner       <= 1'b0;
            err_q       <= 1'b0;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= pick1;
                        err_q       <= sel_err;
                        mem_addr_q  <= sel_addr;
                        mem_data_q  <= sel_wdata;
                        mem_write_q <= sel_we & ~sel_err;
                        mem_read_q  <= ~sel_we & ~sel_err;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q     <= mem_read_q ? mem_data_i : '0;
                    rv0_q       <= ~owner;
                    rv1_q       <= owner;
                    mem_addr_q  <= '0;
                    mem_data_q  <= '0;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    rv0_q      <= 1'b0;
                    rv1_q      <= 1'b0;
                    rdata_q    <= '0;
                    err_q      <= 1'b0;
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m0_rvalid_o = rv0_q;
    assign m0_rdata_o  = rv0_q ? rdata_q : '0;
    assign m0_err_o    = rv0_q & err_q;
    assign m1_rvalid_o = rv1_q;
    assign m1_rdata_o  = rv1_q ? rdata_q : '0;
    assign m1_err_o    = rv1_q & err_q;

    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign mem_write_o = mem_write_q;
    assign mem_read_o  = mem_read_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORDS  = DEPTH / 4;

    logic              clk_i = 1'b0;
    logic              reset_n = 1'b0;
    logic              m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [ADDR_W-1:0] m0_addr_i = '0;
    logic [31:0]       m0_wdata_i = '0;
    logic              m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0]       m0_rdata_o;
    logic              m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [ADDR_W-1:0] m1_addr_i = '0;
    logic [31:0]       m1_wdata_i = '0;
    logic              m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0]       m1_rdata_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_write_o, mem_read_o;
    logic [31:0]       mem_data_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    dmem_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_o(mem_write_o),
        .mem_read_o(mem_read_o), .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    // Single-port memory seen by the DUT: combinational read, write on edge,
    // cleared by the same reset.
    logic [31:0] ram [WORDS];
    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WORDS); i++) ram[i] <= '0;
        end else if (mem_write_o) begin
            ram[mem_addr_o >> 2] <= mem_data_o;
        end
    end
    assign mem_data_i = mem_read_o ? ram[mem_addr_o >> 2] : 32'h0;

    // Reference model and scoreboard
    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       q0[$];
    resp_t       q1[$];
    logic [31:0] mdl_mem [WORDS];
    int          last_srv = 1;
    int          busy_cnt = 0;
    logic        acc_v = 1'b0;
    int unsigned acc_cyc = 0;
    logic [65:0] acc_exp = '0;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    logic [1:0]        exp_g;
    int                win;
    logic              t_we, t_err;
    logic [ADDR_W-1:0] t_a;
    logic [31:0]       t_d, t_rd;
    logic [33:0]       exp_r;
    resp_t             r;

    always @(negedge clk_i) begin
        if (!reset_n) begin
            check("reset_outputs",
                  |{m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o, m1_gnt_o, m1_rvalid_o,
                    m1_rdata_o, m1_err_o, mem_addr_o, mem_data_o, mem_write_o, mem_read_o, busy_o},
                  '0);
            q0.delete();
            q1.delete();
            for (int i = 0; i < int'(WORDS); i++) mdl_mem[i] = '0;
            last_srv = 1;
            busy_cnt = 0;
            acc_v    = 1'b0;
        end else begin
            check("busy", busy_o, (busy_cnt != 0));
            check("mem_port", {mem_addr_o, mem_data_o, mem_write_o, mem_read_o},
                  (acc_v && acc_cyc == cyc) ? acc_exp : 66'd0);

            // Responses due this cycle
            exp_r = '0;
            if (q0.size() > 0 && q0[0].due == cyc) begin
                r = q0.pop_front();
                exp_r = {1'b1, r.rdata, r.err};
            end
            check("m0_resp", {m0_rvalid_o, m0_rdata_o, m0_err_o}, exp_r);
            exp_r = '0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front();
                exp_r = {1'b1, r.rdata, r.err};
            end
            check("m1_resp", {m1_rvalid_o, m1_rdata_o, m1_err_o}, exp_r);

            // Arbitration
            exp_g = 2'b00;
            win   = 0;
            if (busy_cnt == 0 && (m0_req_i || m1_req_i)) begin
                if (m0_req_i && m1_req_i) win = (last_srv == 1) ? 0 : 1;
                else                      win = m1_req_i ? 1 : 0;
                exp_g = (win == 1) ? 2'b10 : 2'b01;
            end
            check("grant", {m1_gnt_o, m0_gnt_o}, exp_g);
            if (busy_cnt > 0) busy_cnt--;

            if (exp_g != 2'b00) begin
                t_we  = (win == 1) ? m1_we_i    : m0_we_i;
                t_a   = (win == 1) ? m1_addr_i  : m0_addr_i;
                t_d   = (win == 1) ? m1_wdata_i : m0_wdata_i;
                t_err = (t_a % 4 != 0) || (t_a > DEPTH - 4);
                t_rd  = (!t_we && !t_err) ? mdl_mem[t_a / 4] : 32'h0;
                if (t_we && !t_err) mdl_mem[t_a / 4] = t_d;
                r.due = cyc + 2;
                r.rdata = t_rd;
                r.err = t_err;
                if (win == 1) q1.push_back(r); else q0.push_back(r);
                last_srv = win;
                busy_cnt = 2;
                acc_v    = 1'b1;
                acc_cyc  = cyc + 1;
                acc_exp  = {t_a, t_d, t_we && !t_err, !t_we && !t_err};
            end
        end
    end

    // Drive one request at posedge+1, hold until granted, drop after the edge.
    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        logic g;
        if (p == 0) begin
            m0_req_i = 1'b1; m0_we_i = we; m0_addr_i = a; m0_wdata_i = d;
        end else begin
            m1_req_i = 1'b1; m1_we_i = we; m1_addr_i = a; m1_wdata_i = d;
        end
        forever begin
            @(negedge clk_i);
            g = (p == 0) ? m0_gnt_o : m1_gnt_o;
            if (g) break;
            n++;
            if (n > 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL grant_timeout port %0d: got no grant, expected one within 60 cycles", p);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        if (p == 0) m0_req_i = 1'b0; else m1_req_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        if (k == 0) return 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
        if (k == 1) return DEPTH + 4 * $urandom_range(0, 8);
        if (k == 2) return $urandom() | 32'h8000_0000;
        return 4 * $urandom_range(0, WORDS - 1);
    endfunction

    task automatic rand_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            cycles($urandom_range(0, 4));
            issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end
    endtask

    initial begin
        cycles(3);
        reset_n = 1'b1;
        cycles(1);

        // Write then read back through port 0
        issue(0, 1'b1, 32'd4, 32'hDEAD_BEEF);
        issue(0, 1'b0, 32'd4, 32'h0);

        // Both ports held high: grants alternate
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'd4; m0_wdata_i = 32'h0;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'd0; m1_wdata_i = 32'h0;
        cycles(12);
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        cycles(3);

        // Error writes leave memory untouched
        issue(1, 1'b1, 32'd6,  32'h1111_1111);
        issue(1, 1'b1, 32'd32, 32'h2222_2222);
        issue(1, 1'b0, 32'd4,  32'h0);
        issue(1, 1'b0, 32'd6,  32'h0);

        // Last legal word
        issue(0, 1'b1, 32'd28, 32'h0102_0304);
        issue(0, 1'b0, 32'd28, 32'h0);

        // Port 0 alone, held high
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'd28;
        cycles(12);
        m0_req_i = 1'b0;
        cycles(3);

        // Randomized contention
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        cycles(4);

        // Reset during ACCESS of a write
        issue(0, 1'b1, 32'd8, 32'hCAFE_F00D);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_outputs",
              {m0_rvalid_o, m0_gnt_o, mem_write_o, mem_read_o, busy_o, mem_addr_o, mem_data_o},
              '0);
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        issue(0, 1'b0, 32'd8, 32'h0);
        issue(1, 1'b0, 32'd4, 32'h0);
        cycles(4);

        check("drain", q0.size() + q1.size(), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
